itwd_mul10: RTL

- Inverse-direction (IFFT) counterpart of the stage-10 trivial twiddle multiplier.
- Takes 16-lane stage-10 butterfly sum/diff outputs and passes sum lanes through unchanged.
- On odd input blocks it multiplies diff lanes by +j; on even blocks diff lanes pass through unchanged.
- Output is registered with a valid pipeline, a frame-aligned block counter, and saturating negation. It sits between the IFFT stage-10 butterfly and the next IFFT stage.

---
 rtl/itwd_mul10_if.sv | 36 +++
 rtl/itwd_mul10.sv | 116 +++++++++++
 2 files changed

// File: rtl/itwd_mul10_if.sv
// Block-level bus for the inverse stage-10 trivial twiddle: butterfly lanes in,
// registered twiddled lanes out, plus framing and saturation status.
interface itwd_mul10_if #(
    parameter int WIDTH     = 12,
    parameter int NUM_LANES = 16,
    parameter int CLK_CNT   = 4
);
    logic                             frame_start;
    logic                             valid_in;
    logic                             sat_clr;
    logic [NUM_LANES-1:0][WIDTH-1:0]  i_sum_re;
    logic [NUM_LANES-1:0][WIDTH-1:0]  i_sum_im;
    logic [NUM_LANES-1:0][WIDTH-1:0]  i_diff_re;
    logic [NUM_LANES-1:0][WIDTH-1:0]  i_diff_im;
    logic [NUM_LANES-1:0][WIDTH-1:0]  o_sum_re;
    logic [NUM_LANES-1:0][WIDTH-1:0]  o_sum_im;
    logic [NUM_LANES-1:0][WIDTH-1:0]  o_diff_re;
    logic [NUM_LANES-1:0][WIDTH-1:0]  o_diff_im;
    logic                             valid_out;
    logic [CLK_CNT-1:0]               blk_cnt;
    logic                             sat_flag;

    modport master (
        output frame_start, valid_in, sat_clr,
        output i_sum_re, i_sum_im, i_diff_re, i_diff_im,
        input  o_sum_re, o_sum_im, o_diff_re, o_diff_im,
        input  valid_out, blk_cnt, sat_flag
    );

    modport slave (
        input  frame_start, valid_in, sat_clr,
        input  i_sum_re, i_sum_im, i_diff_re, i_diff_im,
        output o_sum_re, o_sum_im, o_diff_re, o_diff_im,
        output valid_out, blk_cnt, sat_flag
    );
endinterface

// File: rtl/itwd_mul10.sv
// Inverse stage-10 trivial twiddle: odd blocks rotate diff lanes by +j with
// saturating negation; even blocks and all sum lanes pass through, 1-cycle latency.
module itwd_mul10_lane #(
    parameter int WIDTH = 12
) (
    input  logic             odd,
    input  logic [WIDTH-1:0] diff_re,
    input  logic [WIDTH-1:0] diff_im,
    output logic [WIDTH-1:0] tw_re,
    output logic [WIDTH-1:0] tw_im,
    output logic             sat
);
    logic signed [WIDTH:0] neg_im;

    always_comb begin
        neg_im = -$signed({diff_im[WIDTH-1], diff_im});
        tw_re  = diff_re;
        tw_im  = diff_im;
        sat    = 1'b0;
        if (odd) begin
            tw_im = diff_re;
            // only the most negative input overflows when negated
            if (neg_im[WIDTH] != neg_im[WIDTH-1]) begin
                tw_re = {1'b0, {(WIDTH-1){1'b1}}};
                sat   = 1'b1;
            end else begin
                tw_re = neg_im[WIDTH-1:0];
            end
        end
    end
endmodule

module itwd_mul10 #(
    parameter int WIDTH     = 12,
    parameter int NUM_LANES = 16,
    parameter int CLK_CNT   = 4
) (
    input logic          clk,
    input logic          rst,
    itwd_mul10_if.slave  bus
);
    typedef struct packed {
        logic [NUM_LANES-1:0][WIDTH-1:0] sum_re;
        logic [NUM_LANES-1:0][WIDTH-1:0] sum_im;
        logic [NUM_LANES-1:0][WIDTH-1:0] diff_re;
        logic [NUM_LANES-1:0][WIDTH-1:0] diff_im;
    } blk_t;

    blk_t                            blk_d, blk_q;
    logic                            valid_d, valid_q;
    logic [CLK_CNT-1:0]              blk_cnt_d, blk_cnt_q;
    logic                            sat_flag_d, sat_flag_q;
    logic [CLK_CNT-1:0]              eff_cnt;
    logic                            odd;
    logic [NUM_LANES-1:0][WIDTH-1:0] tw_re, tw_im;
    logic [NUM_LANES-1:0]            lane_sat;

    // a frame_start beat is itself block 0 of the new frame
    assign eff_cnt = (bus.frame_start && bus.valid_in) ? '0 : blk_cnt_q;
    assign odd     = eff_cnt[0];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        itwd_mul10_lane #(.WIDTH(WIDTH)) u_lane (
            .odd     (odd),
            .diff_re (bus.i_diff_re[g]),
            .diff_im (bus.i_diff_im[g]),
            .tw_re   (tw_re[g]),
            .tw_im   (tw_im[g]),
            .sat     (lane_sat[g])
        );
    end

    always_comb begin
        blk_d      = blk_q;
        valid_d    = bus.valid_in;
        blk_cnt_d  = blk_cnt_q;
        sat_flag_d = sat_flag_q;
        if (bus.valid_in) begin
            blk_d.sum_re  = bus.i_sum_re;
            blk_d.sum_im  = bus.i_sum_im;
            blk_d.diff_re = tw_re;
            blk_d.diff_im = tw_im;
            blk_cnt_d     = eff_cnt + CLK_CNT'(1);
        end else if (bus.frame_start) begin
            blk_cnt_d = '0;
        end
        // a new saturation event outranks a simultaneous clear
        if (bus.valid_in && (|lane_sat)) begin
            sat_flag_d = 1'b1;
        end else if (bus.sat_clr) begin
            sat_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q      <= '0;
            valid_q    <= 1'b0;
            blk_cnt_q  <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            blk_q      <= blk_d;
            valid_q    <= valid_d;
            blk_cnt_q  <= blk_cnt_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign bus.o_sum_re  = blk_q.sum_re;
    assign bus.o_sum_im  = blk_q.sum_im;
    assign bus.o_diff_re = blk_q.diff_re;
    assign bus.o_diff_im = blk_q.diff_im;
    assign bus.valid_out = valid_q;
    assign bus.blk_cnt   = blk_cnt_q;
    assign bus.sat_flag  = sat_flag_q;
endmodule
